// File: rtl/subtree_pkg.sv
// Shared types for the subtree done collector: FSM states, report status codes
// and default sizing.
package subtree_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        REPORT  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_ERR     = 2'b01,
        ST_TIMEOUT = 2'b10
    } status_e;

    localparam int DEFAULT_FANOUT  = 10;
    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/subtree_done_collector_if.sv
// Parent/child-facing signal bundle of one collector node. The slave modport is
// the collector itself; the master modport is whoever drives start and children.
interface subtree_done_collector_if
    import subtree_pkg::*;
#(
    parameter int FANOUT = DEFAULT_FANOUT
);
    localparam int CNT_W = $clog2(FANOUT + 1);

    logic              start_i;
    logic [FANOUT-1:0] child_done_i;
    logic [FANOUT-1:0] child_err_i;
    logic              up_valid_o;
    logic              up_ready_i;
    status_e           up_status_o;
    logic [FANOUT-1:0] up_missing_o;
    logic [CNT_W-1:0]  done_cnt_o;
    logic              busy_o;

    modport slave (
        input  start_i,
        input  child_done_i,
        input  child_err_i,
        input  up_ready_i,
        output up_valid_o,
        output up_status_o,
        output up_missing_o,
        output done_cnt_o,
        output busy_o
    );

    modport master (
        output start_i,
        output child_done_i,
        output child_err_i,
        output up_ready_i,
        input  up_valid_o,
        input  up_status_o,
        input  up_missing_o,
        input  done_cnt_o,
        input  busy_o
    );

endinterface

// File: rtl/subtree_popcount.sv
// Combinational population count of a W-bit vector; result is W+1 states wide.
module subtree_popcount #(
    parameter int W = 10
) (
    input  logic [W-1:0]               bits,
    output logic [$clog2(W + 1)-1:0]   count
);
    localparam int CW = $clog2(W + 1);

    always_comb begin
        // NOTE: count gets a value before the loop, so every path assigns it and no latch is inferred.
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/subtree_done_collector.sv
// Collects sticky per-child done/error for one round started by the parent and
// reports a single OK/ERR/TIMEOUT status upward over valid/ready.
module subtree_done_collector
    import subtree_pkg::*;
#(
    parameter int FANOUT  = DEFAULT_FANOUT,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    subtree_done_collector_if.slave  bus
);
    localparam int CNT_W = $clog2(FANOUT + 1);
    localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e            state;
    logic [FANOUT-1:0] mask;
    logic              err_flag;
    logic [TMR_W-1:0]  timer;

    logic [FANOUT-1:0] next_mask;
    logic              next_err;
    logic              all_done;
    logic              timer_expired;
    logic [CNT_W-1:0]  next_cnt;

    // Completion and error look at this cycle's inputs, so the last done reports next cycle.
    always_comb begin
        next_mask     = mask | bus.child_done_i;
        next_err      = err_flag | (|(bus.child_done_i & bus.child_err_i));
        all_done      = &next_mask;
        timer_expired = (TIMEOUT != 0) && (timer == TMR_LAST);
    end

    subtree_popcount #(.W(FANOUT)) u_popcount (
        .bits  (next_mask),
        .count (next_cnt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            mask             <= '0;
            err_flag         <= 1'b0;
            timer            <= '0;
            bus.up_valid_o   <= 1'b0;
            bus.up_status_o  <= ST_OK;
            bus.up_missing_o <= '0;
            bus.done_cnt_o   <= '0;
            bus.busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state          <= COLLECT;
                        mask           <= '0;
                        err_flag       <= 1'b0;
                        timer          <= '0;
                        bus.done_cnt_o <= '0;
                        bus.busy_o     <= 1'b1;
                    end
                end

                COLLECT: begin
                    mask           <= next_mask;
                    err_flag       <= next_err;
                    timer          <= timer + TMR_W'(1);
                    bus.done_cnt_o <= next_cnt;
                    // Completion is tested first so a coincident timer expiry loses.
                    if (all_done) begin
                        state            <= REPORT;
                        bus.up_valid_o   <= 1'b1;
                        bus.up_status_o  <= next_err ? ST_ERR : ST_OK;
                        bus.up_missing_o <= '0;
                    end else if (timer_expired) begin
                        state            <= REPORT;
                        bus.up_valid_o   <= 1'b1;
                        bus.up_status_o  <= ST_TIMEOUT;
                        bus.up_missing_o <= ~next_mask;
                    end
                end

                REPORT: begin
                    if (bus.up_valid_o && bus.up_ready_i) begin
                        state            <= IDLE;
                        bus.up_valid_o   <= 1'b0;
                        bus.up_status_o  <= ST_OK;
                        bus.up_missing_o <= '0;
                        bus.done_cnt_o   <= '0;
                        bus.busy_o       <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
